// File: rtl/mdio_pkg.sv
// Shared MDIO scheduler definitions: clause-22 frame field codes, one-hot
// sequencer states and the frame builder used when a requester is granted.
package mdio_pkg;

   localparam logic [1:0] ST    = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] TA    = 2'b10;

   typedef enum logic [5:0] {
      S_IDLE      = 6'b000001,
      S_GRANT     = 6'b000010,
      S_ISSUE     = 6'b000100,
      S_WAIT_LOW  = 6'b001000,
      S_WAIT_HIGH = 6'b010000,
      S_COMPLETE  = 6'b100000
   } state_t;

   function automatic logic [31:0] mdio_frame(input logic [1:0]  op,
                                              input logic [4:0]  phyad,
                                              input logic [4:0]  regad,
                                              input logic [15:0] data);
      return {ST, op, phyad, regad, TA, data};
   endfunction

endpackage

// File: rtl/mdio_cmd_sched_poll_timer.sv
// Poll interval timer: raises poll_pend every POLL_INTERVAL cycles while the
// poller is enabled and idle, and restarts once the poll transaction finishes.
module mdio_poll_timer #(
   parameter int POLL_INTERVAL = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic poll_en,
   input  logic poll_active,
   input  logic poll_done,
   output logic poll_pend
);

   localparam int CW = $clog2(POLL_INTERVAL);

   logic [CW-1:0] count;

   // The timer is frozen while a poll is pending or in flight, so the interval
   // is measured from the end of one poll to the request for the next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         poll_pend <= 1'b0;
      end else if (!poll_en || poll_done) begin
         count     <= '0;
         poll_pend <= 1'b0;
      end else if (!poll_pend && !poll_active) begin
         if (count == CW'(POLL_INTERVAL - 1)) begin
            count     <= '0;
            poll_pend <= 1'b1;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mdio_cmd_sched.sv
// Shares one MDIO frame shifter between the host MDIC path and a PHY status
// poller: round-robin grant, frame build, completion/timeout tracking.
module mdio_cmd_sched
   import mdio_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR      = 5'd1,
   parameter logic [4:0] POLL_REG      = 5'd1,
   parameter int         LINK_BIT      = 2,
   parameter int         POLL_INTERVAL = 100000,
   parameter int         START_TMO     = 15,
   parameter int         DONE_TMO      = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [4:0]  host_phyad,
   input  logic [4:0]  host_regad,
   input  logic [15:0] host_wdata,
   output logic        host_ack,
   output logic [15:0] host_rdata,
   output logic        host_err,
   input  logic        poll_en,
   output logic [15:0] poll_data,
   output logic        poll_valid,
   output logic        link_up,
   output logic        sh_en,
   output logic [31:0] sh_wdata,
   input  logic        sh_rd_done,
   input  logic        sh_wr_done,
   input  logic [15:0] sh_rdata,
   output logic        busy
);

   state_t      state;
   state_t      state_nxt;
   logic        grant_poll;
   logic        last_poll;
   logic        op_rd;
   logic        err;
   logic [11:0] tmo_cnt;
   logic        done_line;
   logic        host_win;
   logic        poll_pend;
   logic        poll_active;
   logic        poll_done;

   assign done_line   = op_rd ? sh_rd_done : sh_wr_done;
   assign host_win    = host_req && (!poll_pend || last_poll);
   assign poll_active = grant_poll && (state != S_IDLE) && (state != S_GRANT);
   assign poll_done   = grant_poll && (state == S_COMPLETE);

   mdio_poll_timer #(
      .POLL_INTERVAL(POLL_INTERVAL)
   ) u_poll_timer (
      .clk        (clk),
      .rst        (rst),
      .poll_en    (poll_en),
      .poll_active(poll_active),
      .poll_done  (poll_done),
      .poll_pend  (poll_pend)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // A request withdrawn between IDLE and GRANT leaves nothing to issue.
   always_comb begin
      state_nxt  = state;
      sh_en      = 1'b0;
      host_ack   = 1'b0;
      poll_valid = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (host_req || poll_pend) state_nxt = S_GRANT;
         end
         S_GRANT: begin
            state_nxt = (host_req || poll_pend) ? S_ISSUE : S_IDLE;
         end
         S_ISSUE: begin
            sh_en     = 1'b1;
            state_nxt = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            if (!done_line)                       state_nxt = S_WAIT_HIGH;
            else if (tmo_cnt == 12'(START_TMO))   state_nxt = S_COMPLETE;
         end
         S_WAIT_HIGH: begin
            if (done_line)                        state_nxt = S_COMPLETE;
            else if (tmo_cnt == 12'(DONE_TMO))    state_nxt = S_COMPLETE;
         end
         S_COMPLETE: begin
            host_ack   = !grant_poll;
            poll_valid = grant_poll && !err;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Results are written on the edge into COMPLETE so they are already valid
   // while host_ack / poll_valid are high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_poll <= 1'b0;
         last_poll  <= 1'b1;
         op_rd      <= 1'b0;
         err        <= 1'b0;
         tmo_cnt    <= '0;
         sh_wdata   <= '0;
         host_rdata <= '0;
         host_err   <= 1'b0;
         poll_data  <= '0;
         link_up    <= 1'b0;
      end else begin
         case (state)
            S_GRANT: begin
               if (host_win) begin
                  grant_poll <= 1'b0;
                  op_rd      <= !host_we;
                  sh_wdata   <= mdio_frame(host_we ? OP_WR : OP_RD, host_phyad, host_regad,
                                           host_we ? host_wdata : 16'hFFFF);
               end else if (poll_pend) begin
                  grant_poll <= 1'b1;
                  op_rd      <= 1'b1;
                  sh_wdata   <= mdio_frame(OP_RD, PHY_ADDR, POLL_REG, 16'hFFFF);
               end
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               err     <= 1'b0;
            end
            S_WAIT_LOW: begin
               if (!done_line) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == 12'(START_TMO)) begin
                  err <= 1'b1;
                  if (!grant_poll) host_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               if (done_line) begin
                  if (grant_poll) begin
                     poll_data <= sh_rdata;
                     link_up   <= sh_rdata[LINK_BIT];
                  end else begin
                     host_err <= 1'b0;
                     if (op_rd) host_rdata <= sh_rdata;
                  end
               end else if (tmo_cnt == 12'(DONE_TMO)) begin
                  err <= 1'b1;
                  if (!grant_poll) host_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_COMPLETE: begin
               last_poll <= grant_poll;
            end
            default: ;
         endcase
      end
   end

endmodule
